// File: rtl/stream_mux_rr.sv
// stream_mux_rr
// Packet-aware N:1 valid/ready stream multiplexer with a registered output
// stage. The source channel is either taken from `sel` (fixed mode) or picked
// round-robin among valid channels (rr_en=1). Once the first beat of a packet
// is accepted the grant is locked to that channel until the beat carrying
// `last` has been accepted.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   rr_en      1 = round-robin arbitration, 0 = fixed select via sel
//   sel        channel index used when rr_en=0 (values >= N_CH grant nothing)
//   in_data    channel i occupies bits [i*DATA_W +: DATA_W]
//   in_valid   per-channel valid
//   in_last    per-channel end-of-packet marker
//   in_ready   per-channel ready (combinational)
//   out_data   registered output data
//   out_valid  registered output valid
//   out_last   registered end-of-packet marker
//   out_chan   source channel of the current output beat
//   out_ready  downstream ready
module stream_mux_rr #(
  parameter int N_CH   = 4,
  parameter int DATA_W = 8,
  parameter int SEL_W  = $clog2(N_CH)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   rr_en,
  input  logic [SEL_W-1:0]       sel,
  input  logic [N_CH*DATA_W-1:0] in_data,
  input  logic [N_CH-1:0]        in_valid,
  input  logic [N_CH-1:0]        in_last,
  output logic [N_CH-1:0]        in_ready,
  output logic [DATA_W-1:0]      out_data,
  output logic                   out_valid,
  output logic                   out_last,
  output logic [SEL_W-1:0]       out_chan,
  input  logic                   out_ready
);

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  // One bit per encodable index; set only for indices that name a real
  // channel, so a fixed-mode sel outside the channel range never grants.
  localparam int N_SLOT = 2 ** SEL_W;
  localparam logic [N_SLOT-1:0] CHAN_OK = {N_SLOT{1'b1}} >> (N_SLOT - N_CH);

  state_t             state_q, state_d;
  logic [SEL_W-1:0]   lock_q, lock_d;
  logic [SEL_W-1:0]   ptr_q, ptr_d;

  logic               load;
  logic               rr_found;
  logic [SEL_W-1:0]   rr_ch;
  int                 rr_dist;
  int                 rr_best;
  logic [SEL_W-1:0]   cur;
  logic               grant;
  logic [DATA_W-1:0]  cur_data;
  logic               cur_valid;
  logic               cur_last;
  logic               xfer;

  // The output register can take a new beat when it is empty or its current
  // beat is leaving this cycle.
  assign load = !out_valid || out_ready;

  // Round-robin pick: the valid channel closest after ptr, distance 1..N_CH
  // measured upward with wrap, so the last packet's owner has lowest priority.
  always_comb begin
    // NOTE: every variable written here gets a default first so no path
    // leaves it unassigned, which would otherwise infer a latch.
    rr_found = 1'b0;
    rr_ch    = '0;
    rr_dist  = 0;
    rr_best  = N_CH + 1;
    for (int i = 0; i < N_CH; i++) begin
      rr_dist = (i > int'(ptr_q)) ? (i - int'(ptr_q)) : (i - int'(ptr_q) + N_CH);
      if (in_valid[i] && (rr_dist < rr_best)) begin
        rr_best  = rr_dist;
        rr_ch    = SEL_W'(i);
        rr_found = 1'b1;
      end
    end
  end

  // Current channel and whether it is granted at all.
  always_comb begin
    cur   = '0;
    grant = 1'b0;
    if (state_q == LOCKED) begin
      cur   = lock_q;
      grant = 1'b1;
    end else if (rr_en) begin
      cur   = rr_ch;
      grant = rr_found;
    end else begin
      cur   = sel;
      grant = CHAN_OK[sel];
    end
  end

  // Input mux and per-channel ready.
  always_comb begin
    cur_data  = '0;
    cur_valid = 1'b0;
    cur_last  = 1'b0;
    in_ready  = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (cur == SEL_W'(i)) begin
        cur_data  = in_data[i*DATA_W +: DATA_W];
        cur_valid = in_valid[i];
        cur_last  = in_last[i];
        // rst_n gates ready so no producer believes a beat was taken while
        // the output stage is being held in reset.
        in_ready[i] = rst_n && load && grant;
      end
    end
  end

  assign xfer = load && grant && cur_valid;

  // Packet lock and round-robin pointer; ptr moves only when a packet ends.
  always_comb begin
    state_d = state_q;
    lock_d  = lock_q;
    ptr_d   = ptr_q;
    if (xfer) begin
      case (state_q)
        IDLE: begin
          if (cur_last) begin
            ptr_d = cur;
          end else begin
            state_d = LOCKED;
            lock_d  = cur;
          end
        end
        LOCKED: begin
          if (cur_last) begin
            state_d = IDLE;
            ptr_d   = lock_q;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      lock_q  <= '0;
      ptr_q   <= SEL_W'(N_CH - 1);
    end else begin
      state_q <= state_d;
      lock_q  <= lock_d;
      ptr_q   <= ptr_d;
    end
  end

  // Output register: load on transfer, drain when empty slot is not refilled,
  // hold everything while stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      out_chan  <= '0;
    end else if (xfer) begin
      out_valid <= 1'b1;
      out_data  <= cur_data;
      out_last  <= cur_last;
      out_chan  <= cur;
    end else if (load) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_stream_mux_rr.sv
// Self-checking bench for stream_mux_rr: reset checks, a vector table for
// round-robin order and packet locking, hand sequences for stall, mid-packet
// select change, out-of-range select, and mid-packet reset, then randomized
// traffic checked cycle by cycle against a behavioural model.
module tb_stream_mux_rr;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int SW = 2;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            rr_en;
  logic [SW-1:0]   sel;
  logic [N*DW-1:0] in_data;
  logic [N-1:0]    in_valid, in_last, in_ready;
  logic [DW-1:0]   out_data;
  logic            out_valid, out_last, out_ready;
  logic [SW-1:0]   out_chan;

  // Three-channel instance for the non-power-of-two cases.
  logic            rr_en3;
  logic [1:0]      sel3;
  logic [3*DW-1:0] in_data3;
  logic [2:0]      in_valid3, in_last3, in_ready3;
  logic [DW-1:0]   out_data3;
  logic            out_valid3, out_last3, out_ready3;
  logic [1:0]      out_chan3;

  stream_mux_rr #(.N_CH(N), .DATA_W(DW)) dut (
    .clk(clk), .rst_n(rst_n), .rr_en(rr_en), .sel(sel),
    .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
    .in_ready(in_ready), .out_data(out_data), .out_valid(out_valid),
    .out_last(out_last), .out_chan(out_chan), .out_ready(out_ready)
  );

  stream_mux_rr #(.N_CH(3), .DATA_W(DW)) dut3 (
    .clk(clk), .rst_n(rst_n), .rr_en(rr_en3), .sel(sel3),
    .in_data(in_data3), .in_valid(in_valid3), .in_last(in_last3),
    .in_ready(in_ready3), .out_data(out_data3), .out_valid(out_valid3),
    .out_last(out_last3), .out_chan(out_chan3), .out_ready(out_ready3)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Behavioural model of the 4-channel instance.
  bit         m_valid, m_last, m_locked, m_load, m_grant;
  int         m_data, m_chan, m_lock, m_ptr, m_cur;
  logic [N-1:0] m_ready;

  task automatic model_reset();
    m_valid = 0; m_last = 0; m_data = 0; m_chan = 0;
    m_locked = 0; m_lock = 0; m_ptr = N - 1;
  endtask

  task automatic model_comb();
    bit found;
    m_load  = !m_valid || out_ready;
    m_grant = 0;
    m_cur   = 0;
    if (m_locked) begin
      m_cur = m_lock; m_grant = 1;
    end else if (rr_en) begin
      found = 0;
      for (int k = 1; k <= N; k++) begin
        int c;
        c = (m_ptr + k) % N;
        if (!found && in_valid[c]) begin
          found = 1; m_cur = c; m_grant = 1;
        end
      end
    end else begin
      m_cur = int'(sel);
      m_grant = int'(sel) < N;
    end
    m_ready = (m_load && m_grant) ? N'(1 << m_cur) : '0;
  endtask

  task automatic model_seq();
    if (m_ready != 0 && in_valid[m_cur]) begin
      m_valid = 1;
      m_data  = int'(in_data[m_cur*DW +: DW]);
      m_last  = in_last[m_cur];
      m_chan  = m_cur;
      if (m_locked) begin
        if (m_last) begin m_locked = 0; m_ptr = m_lock; end
      end else if (!m_last) begin
        m_locked = 1; m_lock = m_cur;
      end else begin
        m_ptr = m_cur;
      end
    end else if (m_load) begin
      m_valid = 0;
    end
  endtask

  logic [N-1:0] seen_ready;
  logic [2:0]   seen_ready3;
  logic         seen_ov3;

  // One clock: compare ready mid-cycle, then outputs just after the edge.
  task automatic tick(input string tag);
    @(negedge clk);
    model_comb();
    seen_ready  = in_ready;
    seen_ready3 = in_ready3;
    seen_ov3    = out_valid3;
    check({tag, " in_ready"}, 32'(in_ready), 32'(m_ready));
    @(posedge clk);
    model_seq();
    #1;
    check({tag, " out_valid"}, 32'(out_valid), 32'(m_valid));
    check({tag, " out_data"},  32'(out_data),  32'(m_data));
    check({tag, " out_last"},  32'(out_last),  32'(m_last));
    check({tag, " out_chan"},  32'(out_chan),  32'(m_chan));
  endtask

  task automatic fill_data(input int row);
    for (int i = 0; i < N; i++) in_data[i*DW +: DW] = 8'(((row & 15) << 4) | i);
  endtask

  typedef struct {
    bit           rr;
    logic [SW-1:0] sel;
    logic [N-1:0] v;
    logic [N-1:0] l;
    bit           ordy;
    logic [N-1:0] exp_ready;
    bit           exp_ov;
    logic [SW-1:0] exp_chan;
  } vec_t;

  vec_t tbl[$];

  initial begin
    rst_n = 1'b0; rr_en = 1'b1; sel = '0; in_data = '0;
    in_valid = '1; in_last = '1; out_ready = 1'b1;
    rr_en3 = 1'b0; sel3 = 2'd3; in_data3 = '0; in_valid3 = '0;
    in_last3 = '0; out_ready3 = 1'b1;
    model_reset();

    // Reset state: outputs zero, no ready even with every channel valid.
    @(negedge clk);
    check("reset in_ready", 32'(in_ready), 32'h0);
    check("reset out_valid", 32'(out_valid), 32'h0);
    check("reset out_data", 32'(out_data), 32'h0);
    check("reset out_chan", 32'(out_chan), 32'h0);
    @(posedge clk); #2 rst_n = 1'b1;

    // Round-robin order, then a locked 3-beat packet on ch1 with ch2 waiting.
    tbl.push_back('{1'b1, 2'd0, 4'b1111, 4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0});
    tbl.push_back('{1'b1, 2'd0, 4'b1111, 4'b1111, 1'b1, 4'b0010, 1'b1, 2'd1});
    tbl.push_back('{1'b1, 2'd0, 4'b1111, 4'b1111, 1'b1, 4'b0100, 1'b1, 2'd2});
    tbl.push_back('{1'b1, 2'd0, 4'b1111, 4'b1111, 1'b1, 4'b1000, 1'b1, 2'd3});
    tbl.push_back('{1'b1, 2'd0, 4'b1111, 4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0});
    tbl.push_back('{1'b1, 2'd0, 4'b0110, 4'b0000, 1'b1, 4'b0010, 1'b1, 2'd1});
    tbl.push_back('{1'b1, 2'd0, 4'b0110, 4'b0000, 1'b1, 4'b0010, 1'b1, 2'd1});
    tbl.push_back('{1'b1, 2'd0, 4'b0110, 4'b0010, 1'b1, 4'b0010, 1'b1, 2'd1});
    tbl.push_back('{1'b1, 2'd0, 4'b0100, 4'b0100, 1'b1, 4'b0100, 1'b1, 2'd2});
    tbl.push_back('{1'b1, 2'd0, 4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b0, 2'd2});
    for (int r = 0; r < tbl.size(); r++) begin
      rr_en = tbl[r].rr; sel = tbl[r].sel; in_valid = tbl[r].v;
      in_last = tbl[r].l; out_ready = tbl[r].ordy; fill_data(r);
      tick($sformatf("tbl%0d", r));
      check($sformatf("tbl%0d exp_ready", r), 32'(seen_ready), 32'(tbl[r].exp_ready));
      check($sformatf("tbl%0d exp_ov", r), 32'(out_valid), 32'(tbl[r].exp_ov));
      check($sformatf("tbl%0d exp_chan", r), 32'(out_chan), 32'(tbl[r].exp_chan));
      if (tbl[r].exp_ov)
        check($sformatf("tbl%0d exp_data", r), 32'(out_data),
              32'(((r & 15) << 4) | int'(tbl[r].exp_chan)));
    end

    // Fixed select with a downstream stall.
    rr_en = 1'b0; sel = 2'd2; in_valid = 4'b0100; in_last = 4'b0100;
    in_data = 32'h00A5_0000; out_ready = 1'b0;
    tick("stall load");
    check("stall first beat", 32'(out_data), 32'hA5);
    for (int c = 0; c < 3; c++) begin
      tick($sformatf("stall%0d", c));
      check($sformatf("stall%0d ready", c), 32'(seen_ready), 32'h0);
      check($sformatf("stall%0d hold", c), 32'({out_valid, out_data}), 32'h1A5);
    end
    out_ready = 1'b1; in_data = 32'h005A_0000;
    tick("stall release");
    check("release ready", 32'(seen_ready), 32'b0100);
    check("release no bubble", 32'({out_valid, out_data}), 32'h15A);
    in_valid = '0;
    tick("drain");

    // sel changes mid-packet: ch1 keeps the lock until its last beat.
    sel = 2'd1; in_valid = 4'b1010; in_last = 4'b0000; in_data = 32'h3300_1100;
    tick("sel b1");
    sel = 2'd3;
    tick("sel b2");
    check("sel b2 chan", 32'(out_chan), 32'd1);
    check("sel b2 ready", 32'(seen_ready), 32'b0010);
    in_last = 4'b0010;
    tick("sel b3");
    check("sel b3 last", 32'({out_last, out_chan}), 32'b101);
    in_valid = 4'b1000; in_last = 4'b1000;
    tick("sel ch3");
    check("sel ch3 chan", 32'(out_chan), 32'd3);
    in_valid = '0;
    tick("idle");

    // Three channels: out-of-range sel grants nothing; rr wraps modulo 3.
    in_valid3 = 3'b111; in_last3 = 3'b111; in_data3 = 24'h221100;
    for (int c = 0; c < 3; c++) begin
      tick($sformatf("n3 sel3 %0d", c));
      check($sformatf("n3 sel3 ready %0d", c), 32'(seen_ready3), 32'h0);
      check($sformatf("n3 sel3 ov %0d", c), 32'(out_valid3), 32'h0);
    end
    rr_en3 = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick($sformatf("n3 rr %0d", c));
      check($sformatf("n3 rr ready %0d", c), 32'(seen_ready3), 32'(1 << (c % 3)));
      check($sformatf("n3 rr chan %0d", c), 32'(out_chan3), 32'(c % 3));
      check($sformatf("n3 rr data %0d", c), 32'(out_data3), 32'((c % 3) * 8'h11));
    end
    rr_en3 = 1'b0; in_valid3 = '0;

    // Reset in the middle of a ch2 packet.
    rr_en = 1'b1; in_valid = 4'b0100; in_last = 4'b0000; in_data = 32'h0077_0000;
    tick("pkt b1");
    tick("pkt b2");
    #2 rst_n = 1'b0;
    #1;
    check("async rst out", 32'({out_valid, out_last, out_chan, out_data}), 32'h0);
    check("async rst ready", 32'(in_ready), 32'h0);
    model_reset();
    in_valid = '1; in_last = '1; in_data = 32'h4433_2211;
    @(posedge clk); #2 rst_n = 1'b1;
    tick("post rst");
    check("post rst ready", 32'(seen_ready), 32'b0001);
    check("post rst chan", 32'(out_chan), 32'd0);

    // Randomized traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 15) == 0) rr_en = 1'($urandom);
      sel       = 2'($urandom);
      in_valid  = 4'($urandom);
      in_last   = 4'($urandom) & 4'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      in_data   = $urandom;
      tick("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/stream_mux_rr.md
Name: stream_mux_rr

Overview:
- Parametrised successor to the team's single-bit 2:1 gate-level mux.
- Selects one of N_CH valid/ready streams of DATA_W bits onto a single registered output stream.
- Packet-aware: a grant is locked from the first beat to the beat carrying `last`.
- Channel choice is either an external `sel` (fixed mode) or round-robin, chosen at runtime by `rr_en`.
- Sits between multiple producers and a shared downstream sink; one-cycle latency, one beat/cycle.

Parameters:
- N_CH, 4, number of input channels (≥2).
- DATA_W, 8, data width per channel.
- SEL_W, $clog2(N_CH), width of sel and out_chan.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- rr_en  in  1  1 = round-robin arbitration; 0 = fixed select via sel.
- sel  in  SEL_W  channel index used when rr_en=0.
- in_data  in  N_CH*DATA_W  channel i occupies bits [i*DATA_W +: DATA_W].
- in_valid  in  N_CH  per-channel valid.
- in_last  in  N_CH  per-channel end-of-packet marker.
- in_ready  out  N_CH  per-channel ready.
- out_data  out  DATA_W  registered output data.
- out_valid  out  1  registered output valid.
- out_last  out  1  registered end-of-packet marker.
- out_chan  out  SEL_W  source channel of the current output beat.
- out_ready  in  1  downstream ready.

Behaviour:
- Reset (async, rst_n=0): out_valid=0, out_data=0, out_last=0, out_chan=0, state=IDLE, rr pointer ptr=N_CH-1 (channel 0 has first priority); in_ready=0 while in reset.
- load = !out_valid || out_ready; the output register accepts a beat only when load=1.
- Current channel `cur` by state:
  - LOCKED: cur = lock_ch; sel and rr_en are ignored.
  - IDLE, rr_en=1: cur = first i with in_valid[i]=1, searching from ptr+1 upward and wrapping modulo N_CH. If no channel is valid, there is no grant.
  - IDLE, rr_en=0: cur = sel. If sel ≥ N_CH, there is no grant.
- in_ready[i] = load && grant && (i == cur). in_ready is combinational and never depends on in_valid of other channels in LOCKED.
- Transfer on channel i = in_valid[i] && in_ready[i]. On transfer at clk edge:
  - out_data <= channel i data, out_last <= in_last[i], out_chan <= i, out_valid <= 1.
- If load=1 and there is no transfer: out_valid <= 0; out_data, out_last and out_chan hold their values.
- If out_valid=1 and out_ready=0: all outputs hold (stall).
- State machine (2 states):
  - IDLE → LOCKED on a transfer with in_last=0; lock_ch <= i.
  - IDLE, transfer with in_last=1 (single-beat packet): stay IDLE; ptr <= i.
  - LOCKED → IDLE on a transfer with in_last=1; ptr <= lock_ch.
  - LOCKED with in_valid[lock_ch]=0: stay LOCKED; no other channel is served (bubble).
- ptr updates only on packet completion.
- Latency: input beat appears on the output 1 cycle after transfer. Full throughput, back-to-back, when out_ready stays 1.
- Simultaneous out_ready=1 and a new transfer: the old beat is consumed and the new beat is loaded in the same edge; no bubble.
- rr_en or sel change while LOCKED takes effect only after the current packet ends.
- Reset mid-packet drops the lock and the in-flight output beat; ptr returns to N_CH-1.
- N_CH not a power of 2: ptr wrap is modulo N_CH; indices ≥ N_CH are never granted.

Test Plan:
- Reset then rr_en=1, all 4 channels valid with single-beat packets, out_ready=1 → out_chan sequence 0,1,2,3,0; one beat per cycle after 1-cycle latency.
- rr_en=1, ch1 sends 3-beat packet (last on beat 3) while ch2 is valid → ch1 beats appear contiguously on out_chan=1, then ch2; ch2 in_ready=0 throughout ch1 packet.
- rr_en=0, sel=2, ch2 data 0xA5 last=1, out_ready=0 for 3 cycles → out_data=0xA5 held with out_valid=1; in_ready[2]=0 during stall; beat consumed when out_ready=1.
- rr_en=0, sel changes from 1 to 3 mid-packet on ch1 → remaining ch1 beats still forwarded; ch3 served only after ch1 last.
- rr_en=0, sel=3 with N_CH=3 → in_ready all 0, out_valid stays 0.
- rst_n pulsed low mid-packet on ch2 → outputs zero immediately (async); afterwards with all channels valid, channel 0 is granted first.
